// File: rtl/cv32e40p_obi_sram_pkg.sv
// Shared types and constants for the OBI-to-SRAM bridge.
package cv32e40p_obi_sram_pkg;

    localparam int unsigned OBI_DATA_W = 32;
    localparam int unsigned OBI_BE_W   = 4;

    // Per-transaction bookkeeping carried alongside the SRAM access latency.
    typedef struct packed {
        logic valid;
        logic we;
        logic err;
    } obi_resp_tag_t;

endpackage

// File: rtl/cv32e40p_obi_resp_pipe.sv
// Fixed-depth shift register that delays a response tag by SRAM_LATENCY cycles.
module cv32e40p_obi_resp_pipe
    import cv32e40p_obi_sram_pkg::*;
#(
    parameter int unsigned SRAM_LATENCY = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  obi_resp_tag_t tag_i,
    output obi_resp_tag_t tag_o
);

    obi_resp_tag_t [SRAM_LATENCY-1:0] stage_d;
    obi_resp_tag_t [SRAM_LATENCY-1:0] stage_q;

    // Shift every stage one step towards the exit; stage 0 takes the new tag.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = tag_i;
        for (int unsigned i = 1; i < SRAM_LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers; reset drops every in-flight tag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_o = stage_q[SRAM_LATENCY-1];

endmodule

// File: rtl/cv32e40p_obi_sram_bridge.sv
// OBI data-port to single-port SRAM bridge with in-order fixed-latency responses.
module cv32e40p_obi_sram_bridge
    import cv32e40p_obi_sram_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           MEM_WORDS       = 16384,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int unsigned           SRAM_LATENCY    = 1,
    parameter int unsigned           MAX_OUTSTANDING = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         data_req_i,
    output logic                         data_gnt_o,
    input  logic [ADDR_WIDTH-1:0]        data_addr_i,
    input  logic                         data_we_i,
    input  logic [OBI_BE_W-1:0]          data_be_i,
    input  logic [OBI_DATA_W-1:0]        data_wdata_i,
    output logic                         data_rvalid_o,
    output logic [OBI_DATA_W-1:0]        data_rdata_o,
    output logic                         data_err_o,
    input  logic                         stall_i,
    output logic                         sram_ce_o,
    output logic                         sram_we_o,
    output logic [OBI_BE_W-1:0]          sram_be_o,
    output logic [$clog2(MEM_WORDS)-1:0] sram_addr_o,
    output logic [OBI_DATA_W-1:0]        sram_wdata_o,
    input  logic [OBI_DATA_W-1:0]        sram_rdata_i
);

    localparam int unsigned MEM_AW = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    // One extra bit so the window end and below-base wrap never alias.
    localparam int unsigned EXT_W  = ADDR_WIDTH + 1;
    localparam logic [EXT_W-1:0] RANGE_LO   = EXT_W'(BASE_ADDR);
    localparam logic [EXT_W-1:0] RANGE_SPAN = EXT_W'(64'(MEM_WORDS) << 2);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] in_flight;
    logic [EXT_W-1:0] addr_off;
    logic             in_range;
    logic             accept;
    obi_resp_tag_t    tag_in;
    obi_resp_tag_t    tag_out;

    // Response side: exit tag qualifies rdata; writes and errors return zero.
    always_comb begin
        data_rvalid_o = tag_out.valid;
        data_err_o    = tag_out.valid & tag_out.err;
        data_rdata_o  = '0;
        if (tag_out.valid && !tag_out.we && !tag_out.err) begin
            data_rdata_o = sram_rdata_i;
        end
    end

    // Grant, range check and SRAM strobe; a retiring response frees its slot now.
    always_comb begin
        in_flight    = count_q - CNT_W'(data_rvalid_o);
        data_gnt_o   = data_req_i & ~stall_i & (32'(in_flight) < MAX_OUTSTANDING);
        accept       = data_req_i & data_gnt_o;
        addr_off     = {1'b0, data_addr_i} - RANGE_LO;
        in_range     = addr_off < RANGE_SPAN;

        sram_ce_o    = accept & in_range;
        sram_we_o    = 1'b0;
        sram_be_o    = '0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (sram_ce_o) begin
            sram_we_o    = data_we_i;
            sram_be_o    = data_be_i;
            sram_addr_o  = MEM_AW'(addr_off >> 2);
            sram_wdata_o = data_wdata_i;
        end

        tag_in = '0;
        if (accept) begin
            tag_in.valid = 1'b1;
            tag_in.we    = data_we_i;
            tag_in.err   = ~in_range;
        end
    end

    // Outstanding counter next state: accept and retire in one cycle cancel.
    always_comb begin
        count_d = count_q;
        case ({accept, data_rvalid_o})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Outstanding counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    cv32e40p_obi_resp_pipe #(
        .SRAM_LATENCY (SRAM_LATENCY)
    ) u_resp_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tag_i  (tag_in),
        .tag_o  (tag_out)
    );

endmodule

// File: tb/tb_cv32e40p_obi_sram_bridge.sv
// Bench for the OBI-to-SRAM bridge: three instances with latency 1, 2 and 3.
module tb_cv32e40p_obi_sram_bridge;
    import cv32e40p_obi_sram_pkg::*;

    localparam int unsigned SAW = 8;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              stall;
    logic              we;
    logic [31:0]       addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [3:1]        req;
    logic [3:1]        gnt;
    logic [3:1]        rvalid;
    logic [3:1]        err;
    logic [3:1]        ce;
    logic [3:1]        swe;
    logic [3:1][31:0]  rdata;
    logic [3:1][31:0]  swdata;
    logic [3:1][3:0]   sbe;
    logic [3:1][SAW-1:0] saddr;

    logic [31:0] srd1;
    logic [31:0] mem1 [256];
    logic [31:0] p2 [2];
    logic [31:0] p3 [3];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    exp_t sb1[$];
    exp_t sb2[$];
    exp_t sb3[$];

    cv32e40p_obi_sram_bridge #(
        .ADDR_WIDTH(32), .MEM_WORDS(256), .BASE_ADDR(32'h0000_1000),
        .SRAM_LATENCY(1), .MAX_OUTSTANDING(2)
    ) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[1]), .data_gnt_o(gnt[1]),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1]),
        .stall_i(stall), .sram_ce_o(ce[1]), .sram_we_o(swe[1]), .sram_be_o(sbe[1]),
        .sram_addr_o(saddr[1]), .sram_wdata_o(swdata[1]), .sram_rdata_i(srd1)
    );

    cv32e40p_obi_sram_bridge #(
        .ADDR_WIDTH(32), .MEM_WORDS(256), .BASE_ADDR(32'h0),
        .SRAM_LATENCY(2), .MAX_OUTSTANDING(2)
    ) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[2]), .data_gnt_o(gnt[2]),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]), .data_err_o(err[2]),
        .stall_i(stall), .sram_ce_o(ce[2]), .sram_we_o(swe[2]), .sram_be_o(sbe[2]),
        .sram_addr_o(saddr[2]), .sram_wdata_o(swdata[2]), .sram_rdata_i(p2[1])
    );

    cv32e40p_obi_sram_bridge #(
        .ADDR_WIDTH(32), .MEM_WORDS(256), .BASE_ADDR(32'h0),
        .SRAM_LATENCY(3), .MAX_OUTSTANDING(2)
    ) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[3]), .data_gnt_o(gnt[3]),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rvalid[3]), .data_rdata_o(rdata[3]), .data_err_o(err[3]),
        .stall_i(stall), .sram_ce_o(ce[3]), .sram_we_o(swe[3]), .sram_be_o(sbe[3]),
        .sram_addr_o(saddr[3]), .sram_wdata_o(swdata[3]), .sram_rdata_i(p3[2])
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Latency-1 byte-maskable SRAM; idle cycles return all-ones.
    always @(posedge clk) begin
        if (ce[1]) begin
            for (int b = 0; b < 4; b++) begin
                if (swe[1] && sbe[1][b]) mem1[saddr[1]][8*b +: 8] <= swdata[1][8*b +: 8];
            end
            srd1 <= mem1[saddr[1]];
        end else begin
            srd1 <= 32'hFFFF_FFFF;
        end
    end

    // Pattern SRAMs with latency 2 and 3: data = C0DE0000 | word address.
    always @(posedge clk) begin
        p2[0] <= ce[2] ? (32'hC0DE_0000 | 32'(saddr[2])) : 32'hFFFF_FFFF;
        p2[1] <= p2[0];
        p3[0] <= ce[3] ? (32'hC0DE_0000 | 32'(saddr[3])) : 32'hFFFF_FFFF;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [1:0] d, input logic [31:0] rd, input logic e);
        exp_t x;
        x.rdata = rd;
        x.err   = e;
        x.cyc   = cyc;
        case (d)
            2'd1:    sb1.push_back(x);
            2'd2:    sb2.push_back(x);
            default: sb3.push_back(x);
        endcase
    endtask

    task automatic check_resp(input logic [1:0] d);
        exp_t x;
        bit   have = 1'b0;
        case (d)
            2'd1:    if (sb1.size() > 0) begin x = sb1.pop_front(); have = 1'b1; end
            2'd2:    if (sb2.size() > 0) begin x = sb2.pop_front(); have = 1'b1; end
            default: if (sb3.size() > 0) begin x = sb3.pop_front(); have = 1'b1; end
        endcase
        chk($sformatf("rvalid_expected_d%0d", d), 32'(have), 32'd1);
        if (have) begin
            chk($sformatf("rdata_d%0d", d), rdata[d], x.rdata);
            chk($sformatf("err_d%0d", d), 32'(err[d]), 32'(x.err));
            chk($sformatf("latency_d%0d", d), 32'(cyc - x.cyc), 32'(d));
        end
    endtask

    // Response monitor: every rvalid must match the oldest expected entry.
    always @(negedge clk) begin
        for (int d = 1; d <= 3; d++) begin
            if (rvalid[d]) check_resp(2'(d));
        end
    end

    // One OBI transaction: wait (bounded) for grant, check the SRAM side, queue the response.
    task automatic issue(input logic [1:0] d, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input logic [SAW-1:0] exp_saddr);
        bit got = 1'b0;
        @(posedge clk); #1;
        req[d] = 1'b1; we = w; addr = a; be = b; wdata = wd;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (gnt[d]) got = 1'b1;
        end
        chk("grant_seen", 32'(got), 32'd1);
        if (got) begin
            chk("sram_ce", 32'(ce[d]), 32'(!exp_err));
            if (!exp_err) begin
                chk("sram_addr", 32'(saddr[d]), 32'(exp_saddr));
                chk("sram_we", 32'(swe[d]), 32'(w));
                if (w) begin
                    chk("sram_be", 32'(sbe[d]), 32'(b));
                    chk("sram_wdata", swdata[d], wd);
                end
            end
            push(d, exp_rd, exp_err);
        end
        @(posedge clk); #1;
        req[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] gexp;
        int         word;
        rst_n = 1'b0; stall = 1'b0; req = '0;
        we = 1'b0; addr = '0; be = '0; wdata = '0;

        // Reset state.
        @(negedge clk);
        for (int d = 1; d <= 3; d++) begin
            chk("rst_gnt", 32'(gnt[d]), 32'd0);
            chk("rst_rvalid", 32'(rvalid[d]), 32'd0);
            chk("rst_rdata", rdata[d], 32'd0);
            chk("rst_err", 32'(err[d]), 32'd0);
            chk("rst_ce", 32'(ce[d]), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Write, read back, partial write, read back.
        issue(2'd1, 1'b1, 32'h1100, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, 8'h40);
        issue(2'd1, 1'b0, 32'h1100, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 8'h40);
        issue(2'd1, 1'b1, 32'h1100, 4'b0010, 32'h0000_AB00, 32'h0, 1'b0, 8'h40);
        issue(2'd1, 1'b0, 32'h1100, 4'h0, 32'h0, 32'hDEAD_ABEF, 1'b0, 8'h40);

        // Range boundaries: end of window, below base, top-of-space, last word.
        issue(2'd1, 1'b0, 32'h1400, 4'h0, 32'h0, 32'h0, 1'b1, 8'h0);
        issue(2'd1, 1'b1, 32'h1400, 4'hF, 32'h1234_5678, 32'h0, 1'b1, 8'h0);
        issue(2'd1, 1'b0, 32'h0FFC, 4'h0, 32'h0, 32'h0, 1'b1, 8'h0);
        issue(2'd1, 1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0, 32'h0, 1'b1, 8'h0);
        issue(2'd1, 1'b1, 32'h13FC, 4'hF, 32'h1234_5678, 32'h0, 1'b0, 8'hFF);
        issue(2'd1, 1'b0, 32'h13FF, 4'h0, 32'h0, 32'h1234_5678, 1'b0, 8'hFF);

        // Back-to-back reads at latency 1: grant every cycle.
        @(posedge clk); #1;
        req[1] = 1'b1; we = 1'b0; addr = 32'h1100; be = 4'h0; wdata = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("gnt_b2b", 32'(gnt[1]), 32'd1);
            if (gnt[1]) push(2'd1, 32'hDEAD_ABEF, 1'b0);
            @(posedge clk); #1;
        end
        req[1] = 1'b0;

        // Stall: no grant while stalled, one grant right after release.
        @(posedge clk); #1;
        stall = 1'b1; req[1] = 1'b1; addr = 32'h1100;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("gnt_stalled", 32'(gnt[1]), 32'd0);
        end
        @(posedge clk); #1;
        stall = 1'b0;
        @(negedge clk);
        chk("gnt_after_stall", 32'(gnt[1]), 32'd1);
        if (gnt[1]) push(2'd1, 32'hDEAD_ABEF, 1'b0);
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(negedge clk);
        chk("gnt_idle", 32'(gnt[1]), 32'd0);

        // Outstanding limit at latency 3: grants 1,1,0,1,1 while req held.
        gexp = 5'b11011;
        word = 16;
        @(posedge clk); #1;
        req[3] = 1'b1; we = 1'b0; addr = 32'(word) << 2;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("gnt_limit_c%0d", k), 32'(gnt[3]), 32'(gexp[k]));
            if (gnt[3]) begin
                push(2'd3, 32'hC0DE_0000 | 32'(word), 1'b0);
                word++;
            end
            @(posedge clk); #1;
            addr = 32'(word) << 2;
        end
        req[3] = 1'b0;
        repeat (6) @(negedge clk);

        // Reset one cycle after a latency-2 read grant drops the response.
        @(posedge clk); #1;
        req[2] = 1'b1; we = 1'b0; addr = 32'h20;
        @(negedge clk);
        chk("gnt_pre_reset", 32'(gnt[2]), 32'd1);
        @(posedge clk); #1;
        req[2] = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        chk("rvalid_in_reset", 32'(rvalid[2]), 32'd0);
        chk("count_after_reset", 32'(u_dut2.count_q), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rvalid_after_reset", 32'(rvalid[2]), 32'd0);
        end
        @(posedge clk); #1;
        req[2] = 1'b1; addr = 32'h24;
        @(negedge clk);
        chk("gnt_post_reset", 32'(gnt[2]), 32'd1);
        if (gnt[2]) push(2'd2, 32'hC0DE_0009, 1'b0);
        @(posedge clk); #1;
        req[2] = 1'b0;

        // Every queued response must have been seen.
        repeat (6) @(negedge clk);
        chk("sb1_empty", 32'(sb1.size()), 32'd0);
        chk("sb2_empty", 32'(sb2.size()), 32'd0);
        chk("sb3_empty", 32'(sb3.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
